avalon_ram_test_master: RTL and testbench
=========================================

Name: avalon_ram_test_master

Overview:
- Avalon-MM master that drives the on-chip RAM's s1 slave port.
- Two modes:
  - Fill: writes a programmable linear pattern over a word range.
  - Verify: reads the same range back and compares each word against the expected pattern.
- Sits between the alarm-clock control logic (or a debug PIO) and the RAM interconnect. Used for power-on memory test and for clearing or initialising RAM regions without the CPU.

Parameters:
- ADDR_W, 11, word-address width of the slave (2048 words).
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- READ_LATENCY, 1, fixed slave read latency in cycles after read acceptance; legal values 1..3.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin an operation; sampled only in IDLE.
- mode  in  1  0 = fill, 1 = verify; sampled with start.
- base_addr  in  ADDR_W  first word address; sampled with start.
- word_count  in  ADDR_W+1  number of words, 0..2^ADDR_W; sampled with start.
- seed  in  DATA_W  pattern seed; sampled with start.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- error_count  out  ADDR_W+1  mismatches seen in the last verify.
- first_err_addr  out  ADDR_W  address of the first mismatch.
- first_err_data  out  DATA_W  data read at the first mismatch.
- avm_address  out  ADDR_W  Avalon word address.
- avm_byteenable  out  DATA_W/8  always all ones while read or write is asserted; 0 otherwise.
- avm_read  out  1  Avalon read request.
- avm_write  out  1  Avalon write request.
- avm_writedata  out  DATA_W  write data.
- avm_waitrequest  in  1  slave stall; tie 0 for the RAM.
- avm_readdata  in  DATA_W  read data.

Behaviour:
- Reset (asynchronous, reset_n low):
  - All outputs go to 0; state goes to IDLE.
  - Any in-flight transfer is abandoned with no completion or done pulse.
- Expected pattern: word i (0-based) = seed + i, modulo 2^DATA_W.
- Address sequencing:
  - Word i is at address (base_addr + i) mod 2^ADDR_W, so the range wraps past the top of memory.
  - A word_count of 2^ADDR_W covers every word exactly once.
- States: IDLE, WRITE, RD_REQ, RD_WAIT, FINISH.
- IDLE:
  - start=1 latches mode, base_addr, word_count and seed into internal registers.
  - start also clears error_count, first_err_addr and first_err_data.
  - Transitions:
    - word_count=0 -> FINISH (no bus activity).
    - mode=0 -> WRITE.
    - mode=1 -> RD_REQ.
  - start is ignored in every state other than IDLE.
- WRITE:
  - Drives avm_write=1 with the current address and pattern.
  - Address and data are held stable while avm_waitrequest=1.
  - On acceptance (waitrequest=0): index increments; after the last word -> FINISH.
  - With waitrequest tied low, one word is written per clock; back-to-back writes are required.
- RD_REQ:
  - Drives avm_read=1, held stable while waitrequest=1.
  - On acceptance -> RD_WAIT. Only one read is outstanding.
- RD_WAIT:
  - avm_read=0. Counts READ_LATENCY cycles after the acceptance edge.
  - Samples avm_readdata at the end of cycle READ_LATENCY and compares it with the expected word.
  - On mismatch:
    - error_count increments, saturating at all ones.
    - If this is the first mismatch of the operation, first_err_addr and first_err_data are latched.
  - Then -> RD_REQ, or -> FINISH after the last word.
  - Throughput is 1+READ_LATENCY cycles per word with no stalls.
- FINISH:
  - done=1 and busy=0 for exactly one cycle, then -> IDLE.
  - Error outputs hold until the next accepted start.
- busy:
  - High from the cycle after start is accepted up to, but not including, FINISH.
  - With word_count=0, busy stays low and done pulses on the cycle after start.
- Timing example: start at cycle 0 -> first avm_write or avm_read at cycle 1.
- Bus rules:
  - avm_read and avm_write are never high together.
  - Both are low in IDLE and FINISH.
  - In fill mode, error outputs remain 0.

Test Plan:
- Fill, no stall: base 0x010, count 4, seed 0x00001000 -> writes 0x1000..0x1003 to 0x010..0x013 on cycles 1..4; done at cycle 5; avm_byteenable=4'hF throughout.
- Verify pass against a RAM model with READ_LATENCY=1: same range -> 4 reads at 2-cycle spacing; done pulses; error_count=0.
- Verify with a corrupted word 0x012 = 0xDEADBEEF -> error_count=1; first_err_addr=0x012; first_err_data=0xDEADBEEF.
- Random avm_waitrequest during fill and verify -> address and data held stable while stalled; no word dropped or duplicated; final RAM contents and error_count=0 unchanged.
- Wrap: base 0x7FE, count 4 -> addresses 0x7FE, 0x7FF, 0x000, 0x001. Count 0 -> no bus activity; done on the cycle after start; busy never high.
- reset_n pulsed low mid-fill after 2 words -> all outputs 0 immediately, no done pulse; a subsequent start runs normally. A start asserted while busy is ignored.

Source files
------------

// File: rtl/avalon_ram_test_master.sv
`default_nettype none
// avalon_ram_test_master: Avalon-MM master that fills a wrapping word range with seed+i
// or reads it back and records mismatches (count, first failing address and data).
module avalon_ram_test_master #(
  parameter int ADDR_W       = 11,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                mode,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     word_count,
  input  logic [DATA_W-1:0]   seed,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W:0]     error_count,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic [DATA_W-1:0]   first_err_data,
  output logic [ADDR_W-1:0]   avm_address,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  input  logic                avm_waitrequest,
  input  logic [DATA_W-1:0]   avm_readdata
);

  localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WRITE   = 3'd1,
    S_RD_REQ  = 3'd2,
    S_RD_WAIT = 3'd3,
    S_FINISH  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ADDR_W:0]     remain_q, remain_d;
  logic [1:0]          lat_q, lat_d;
  logic [ADDR_W:0]     err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0]   ferr_addr_q, ferr_addr_d;
  logic [DATA_W-1:0]   ferr_data_q, ferr_data_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      remain_q    <= '0;
      lat_q       <= '0;
      err_cnt_q   <= '0;
      ferr_addr_q <= '0;
      ferr_data_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      remain_q    <= remain_d;
      lat_q       <= lat_d;
      err_cnt_q   <= err_cnt_d;
      ferr_addr_q <= ferr_addr_d;
      ferr_data_q <= ferr_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    remain_d    = remain_q;
    lat_d       = lat_q;
    err_cnt_d   = err_cnt_q;
    ferr_addr_d = ferr_addr_q;
    ferr_data_d = ferr_data_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d      = base_addr;
          data_d      = seed;
          remain_d    = word_count;
          lat_d       = '0;
          err_cnt_d   = '0;
          ferr_addr_d = '0;
          ferr_data_d = '0;
          if (word_count == '0) state_d = S_FINISH;
          else if (mode)        state_d = S_RD_REQ;
          else                  state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        if (!avm_waitrequest) begin
          addr_d   = addr_q + ADDR_W'(1);
          data_d   = data_q + DATA_W'(1);
          remain_d = remain_q - (ADDR_W+1)'(1);
          if (remain_q == (ADDR_W+1)'(1)) state_d = S_FINISH;
        end
      end

      S_RD_REQ: begin
        if (!avm_waitrequest) begin
          lat_d   = '0;
          state_d = S_RD_WAIT;
        end
      end

      S_RD_WAIT: begin
        if (lat_q == LAT_LAST) begin
          // The first mismatch is recognised by the count still being zero.
          if (avm_readdata != data_q) begin
            if (err_cnt_q == '0) begin
              ferr_addr_d = addr_q;
              ferr_data_d = avm_readdata;
            end
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + (ADDR_W+1)'(1);
          end
          addr_d   = addr_q + ADDR_W'(1);
          data_d   = data_q + DATA_W'(1);
          remain_d = remain_q - (ADDR_W+1)'(1);
          state_d  = (remain_q == (ADDR_W+1)'(1)) ? S_FINISH : S_RD_REQ;
        end else begin
          lat_d = lat_q + 2'(1);
        end
      end

      S_FINISH: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  assign busy           = (state_q == S_WRITE) || (state_q == S_RD_REQ) || (state_q == S_RD_WAIT);
  assign done           = (state_q == S_FINISH);
  assign avm_write      = (state_q == S_WRITE);
  assign avm_read       = (state_q == S_RD_REQ);
  assign avm_byteenable = (avm_read || avm_write) ? '1 : '0;
  assign avm_address    = addr_q;
  assign avm_writedata  = data_q;
  assign error_count    = err_cnt_q;
  assign first_err_addr = ferr_addr_q;
  assign first_err_data = ferr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_avalon_ram_test_master.sv
`default_nettype none
// tb_avalon_ram_test_master: scoreboard bench with a latency-1 RAM model and optional
// random waitrequest; expected bus transfers are queued at start and popped at acceptance.
module tb_avalon_ram_test_master;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        mode;
  logic [10:0] base_addr;
  logic [11:0] word_count;
  logic [31:0] seed;
  logic        busy;
  logic        done;
  logic [11:0] error_count;
  logic [10:0] first_err_addr;
  logic [31:0] first_err_data;
  logic [10:0] avm_address;
  logic [3:0]  avm_byteenable;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  int n_total = 0;
  int n_bad   = 0;
  int n_done  = 0;
  bit stall_en = 0;

  logic [31:0] mem    [0:2047];
  logic [31:0] golden [0:2047];
  logic        bd_we;
  logic [10:0] bd_addr;
  logic [31:0] bd_data;

  logic [10:0] exp_wa[$];
  logic [31:0] exp_wd[$];
  logic [10:0] exp_ra[$];

  avalon_ram_test_master #(.ADDR_W(11), .DATA_W(32), .READ_LATENCY(1)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .mode           (mode),
    .base_addr      (base_addr),
    .word_count     (word_count),
    .seed           (seed),
    .busy           (busy),
    .done           (done),
    .error_count    (error_count),
    .first_err_addr (first_err_addr),
    .first_err_data (first_err_data),
    .avm_address    (avm_address),
    .avm_byteenable (avm_byteenable),
    .avm_read       (avm_read),
    .avm_write      (avm_write),
    .avm_writedata  (avm_writedata),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata   (avm_readdata)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // RAM model: write on acceptance, registered read data one cycle after acceptance.
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (avm_write && !avm_waitrequest) mem[avm_address] <= avm_writedata;
    if (avm_read && !avm_waitrequest) avm_readdata <= mem[avm_address];
  end

  initial begin
    avm_waitrequest = 0;
    forever begin
      @(posedge clk);
      #1 avm_waitrequest = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // Bus monitor: byteenable, exclusivity, stall hold and scoreboard pops.
  initial begin : mon
    logic        prev_stall;
    logic [1:0]  prev_rw;
    logic [10:0] prev_a;
    logic [31:0] prev_d;
    prev_stall = 0;
    prev_rw = 0;
    prev_a = 0;
    prev_d = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_stall = 0;
      end else begin
        if (done) n_done++;
        check_eq("byteenable", avm_byteenable, (avm_read || avm_write) ? 4'hF : 4'h0);
        if (avm_read || avm_write) check_eq("rw_exclusive", avm_read & avm_write, 1'b0);
        if (prev_stall) begin
          check_eq("hold_rw", {avm_read, avm_write}, prev_rw);
          check_eq("hold_addr", avm_address, prev_a);
          if (prev_rw[0]) check_eq("hold_data", avm_writedata, prev_d);
        end
        prev_stall = (avm_read || avm_write) && avm_waitrequest;
        prev_rw = {avm_read, avm_write};
        prev_a = avm_address;
        prev_d = avm_writedata;
        if (avm_write && !avm_waitrequest) begin
          check_eq("wr_expected", exp_wa.size() != 0, 1'b1);
          if (exp_wa.size() != 0) begin
            check_eq("wr_addr", avm_address, exp_wa.pop_front());
            check_eq("wr_data", avm_writedata, exp_wd.pop_front());
          end
        end
        if (avm_read && !avm_waitrequest) begin
          check_eq("rd_expected", exp_ra.size() != 0, 1'b1);
          if (exp_ra.size() != 0) check_eq("rd_addr", avm_address, exp_ra.pop_front());
        end
      end
    end
  end

  task automatic flush_queues();
    exp_wa.delete();
    exp_wd.delete();
    exp_ra.delete();
  endtask

  task automatic backdoor(input logic [10:0] a, input logic [31:0] d);
    @(posedge clk);
    #1 bd_we = 1; bd_addr = a; bd_data = d;
    golden[a] = d;
    @(posedge clk);
    #1 bd_we = 0;
  endtask

  // Queue the expected transfers and compute expected error results from the golden image.
  task automatic push_op(input logic m, input logic [10:0] b, input logic [11:0] n,
                         input logic [31:0] s, output int eerr,
                         output logic [10:0] efa, output logic [31:0] efd);
    logic [10:0] a;
    logic [31:0] d;
    eerr = 0; efa = 0; efd = 0;
    for (int i = 0; i < int'(n); i++) begin
      a = b + i[10:0];
      d = s + i;
      if (!m) begin
        exp_wa.push_back(a);
        exp_wd.push_back(d);
        golden[a] = d;
      end else begin
        exp_ra.push_back(a);
        if (golden[a] != d) begin
          if (eerr == 0) begin efa = a; efd = golden[a]; end
          eerr++;
        end
      end
    end
  endtask

  task automatic pulse_start(input logic m, input logic [10:0] b, input logic [11:0] n,
                             input logic [31:0] s);
    @(posedge clk);
    #1 start = 1; mode = m; base_addr = b; word_count = n; seed = s;
    @(posedge clk);
    #1 start = 0;
  endtask

  // exp_done < 0 skips cycle-exact timing (used when stalls are random).
  task automatic run_op(input logic m, input logic [10:0] b, input logic [11:0] n,
                        input logic [31:0] s, input int exp_done, input bit poke);
    int eerr;
    logic [10:0] efa;
    logic [31:0] efd;
    int got, first;
    bit busy_seen;
    push_op(m, b, n, s, eerr, efa, efd);
    pulse_start(m, b, n, s);
    got = 0; first = 0; busy_seen = 0;
    for (int k = 1; k <= 10000; k++) begin
      @(negedge clk);
      if ((avm_read || avm_write) && first == 0) first = k;
      if (busy) busy_seen = 1;
      if (done) begin got = k; break; end
      if (poke && k == 2) begin
        start = 1; mode = ~m; base_addr = b + 11'd5; word_count = 12'd3; seed = ~s;
      end
      if (poke && k == 3) start = 0;
    end
    if (exp_done >= 0) check_eq("done_cycle", got, exp_done);
    else check_eq("done_seen", got > 0, 1'b1);
    check_eq("busy_seen", busy_seen, n != 0);
    if (exp_done >= 0 && n != 0) check_eq("first_bus_cycle", first, 1);
    if (got > 0) begin
      @(negedge clk);
      check_eq("done_one_cycle", done, 1'b0);
    end
    check_eq("error_count", error_count, eerr);
    check_eq("first_err_addr", first_err_addr, efa);
    check_eq("first_err_data", first_err_data, efd);
    check_eq("wr_left", exp_wa.size(), 0);
    check_eq("rd_left", exp_ra.size(), 0);
    flush_queues();
  endtask

  initial begin : main
    int nmis, eerr, nd;
    logic [10:0] efa;
    logic [31:0] efd;
    reset_n = 0; start = 0; mode = 0; base_addr = 0; word_count = 0; seed = 0;
    bd_we = 0; bd_addr = 0; bd_data = 0;
    for (int i = 0; i < 2048; i++) golden[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_bus", {avm_read, avm_write, avm_byteenable, avm_address, avm_writedata}, 0);
    check_eq("rst_err", {error_count, first_err_addr, first_err_data}, 0);
    @(negedge clk);
    reset_n = 1;

    run_op(1'b0, 11'h010, 12'd4, 32'h0000_1000, 5, 0);
    run_op(1'b1, 11'h010, 12'd4, 32'h0000_1000, 9, 0);
    backdoor(11'h012, 32'hDEAD_BEEF);
    run_op(1'b1, 11'h010, 12'd4, 32'h0000_1000, 9, 0);
    run_op(1'b1, 11'h010, 12'd0, 32'h0000_1000, 1, 0);
    run_op(1'b0, 11'h010, 12'd0, 32'h0000_1000, 1, 0);

    run_op(1'b0, 11'h7FE, 12'd4, 32'hAAAA_0000, 5, 0);
    run_op(1'b1, 11'h7FE, 12'd4, 32'hAAAA_0000, 9, 0);

    stall_en = 1;
    run_op(1'b0, 11'h100, 12'd20, 32'h1234_5678, -1, 1);
    run_op(1'b1, 11'h100, 12'd20, 32'h1234_5678, -1, 1);
    stall_en = 0;
    nmis = 0;
    for (int i = 0; i < 20; i++) if (mem[11'h100 + i] !== golden[11'h100 + i]) nmis++;
    check_eq("ram_content", nmis, 0);

    // Asynchronous reset after two words of a fill.
    push_op(1'b0, 11'h040, 12'd10, 32'h0000_0055, eerr, efa, efd);
    pulse_start(1'b0, 11'h040, 12'd10, 32'h0000_0055);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 reset_n = 0;
    nd = n_done;
    #1;
    check_eq("arst_busy", busy, 1'b0);
    check_eq("arst_done", done, 1'b0);
    check_eq("arst_bus", {avm_read, avm_write, avm_byteenable, avm_address, avm_writedata}, 0);
    check_eq("arst_err", {error_count, first_err_addr, first_err_data}, 0);
    check_eq("arst_words_left", exp_wa.size(), 8);
    flush_queues();
    repeat (3) @(negedge clk);
    reset_n = 1;
    repeat (3) @(negedge clk);
    check_eq("arst_no_done", n_done, nd);
    run_op(1'b0, 11'h040, 12'd10, 32'h0000_0055, 11, 0);
    run_op(1'b1, 11'h040, 12'd10, 32'h0000_0055, 21, 0);

    run_op(1'b0, 11'h300, 12'h800, 32'hF000_0000, 2049, 0);
    run_op(1'b1, 11'h300, 12'h800, 32'hF000_0000, 4097, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
